// File: rtl/coord_mem_arbiter_pkg.sv
// Shared types and default sizes for the coordinate memory arbiter.
// Optional performance counters are enabled with COORD_ARB_PERF_EN.
package coord_mem_pkg;

    localparam int COORD_ADDR_W = 8;
    localparam int COORD_DATA_W = 8;
    localparam int COORD_DEPTH  = 256;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_t;

    typedef enum logic {
        RR_WR = 1'b0,
        RR_RD = 1'b1
    } rr_side_t;

    typedef struct packed {
        logic [COORD_DATA_W-1:0] x;
        logic [COORD_DATA_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/coord_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the X/Y RAMs.
// The perf counter signals exist only when COORD_ARB_PERF_EN is defined.
interface coord_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic              clear;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_x;
    logic [DATA_W-1:0] wr_y;
    logic              seal;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_x;
    logic [DATA_W-1:0] rsp_y;
    logic              rsp_err;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              sealed;
    logic [ADDR_W-1:0] xmem_address;
    logic [DATA_W-1:0] xmem_data;
    logic              xmem_wren;
    logic [DATA_W-1:0] xmem_q;
    logic [ADDR_W-1:0] ymem_address;
    logic [DATA_W-1:0] ymem_data;
    logic              ymem_wren;
    logic [DATA_W-1:0] ymem_q;
`ifdef COORD_ARB_PERF_EN
    logic [15:0]       conflict_cnt;
    logic [15:0]       wr_stall_cnt;
`endif

    modport slave (
        input  clear, wr_valid, wr_x, wr_y, seal, rd_valid, rd_addr,
        input  xmem_q, ymem_q,
        output wr_ready, rd_ready, rsp_valid, rsp_x, rsp_y, rsp_err,
        output count, full, sealed,
        output xmem_address, xmem_data, xmem_wren,
        output ymem_address, ymem_data, ymem_wren
`ifdef COORD_ARB_PERF_EN
        , output conflict_cnt, wr_stall_cnt
`endif
    );

    modport master (
        output clear, wr_valid, wr_x, wr_y, seal, rd_valid, rd_addr,
        output xmem_q, ymem_q,
        input  wr_ready, rd_ready, rsp_valid, rsp_x, rsp_y, rsp_err,
        input  count, full, sealed,
        input  xmem_address, xmem_data, xmem_wren,
        input  ymem_address, ymem_data, ymem_wren
`ifdef COORD_ARB_PERF_EN
        , input conflict_cnt, wr_stall_cnt
`endif
    );

endinterface

// File: rtl/coord_mem_arbiter_rr.sv
// Two-way round-robin arbiter (writer vs reader) for a shared single-port RAM.
// The remembered side only moves when both requesters compete in the same cycle.
module rr_arbiter2
    import coord_mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req_wr_i,
    input  logic   req_rd_i,
    output grant_t gnt_o
);

    rr_side_t rr_last_q, rr_last_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= RR_RD;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    always_comb begin
        gnt_o     = GNT_NONE;
        rr_last_d = rr_last_q;
        if (req_wr_i && req_rd_i) begin
            if (rr_last_q == RR_RD) begin
                gnt_o     = GNT_WR;
                rr_last_d = RR_WR;
            end else begin
                gnt_o     = GNT_RD;
                rr_last_d = RR_RD;
            end
        end else if (req_wr_i) begin
            gnt_o = GNT_WR;
        end else if (req_rd_i) begin
            gnt_o = GNT_RD;
        end
    end

endmodule

// File: rtl/coord_mem_arbiter.sv
// Owns the X/Y coordinate RAMs: appends pairs, serves indexed reads, seals the table.
// Define COORD_ARB_PERF_EN to add the conflict and writer-stall counters.
module coord_mem_arbiter
    import coord_mem_pkg::*;
#(
    parameter int ADDR_W = COORD_ADDR_W,
    parameter int DATA_W = COORD_DATA_W,
    parameter int DEPTH  = COORD_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    coord_mem_arbiter_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [ADDR_W:0]   count_q, count_d;
    logic              sealed_q, sealed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wx_q, wx_d;
    logic [DATA_W-1:0] wy_q, wy_d;
    logic              wren_q, wren_d;
    logic              pend_rd_q, pend_rd_d;
    logic              pend_err_q, pend_err_d;
    logic              rsp_valid_q, rsp_err_q;

    logic   full;
    logic   wr_elig;
    logic   rd_elig;
    grant_t gnt;

    assign full    = (count_q == DEPTH_C);
    assign wr_elig = bus.wr_valid & ~sealed_q & ~full & ~bus.clear;
    assign rd_elig = bus.rd_valid & ~bus.clear;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_wr_i (wr_elig),
        .req_rd_i (rd_elig),
        .gnt_o    (gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            sealed_q    <= 1'b0;
            addr_q      <= '0;
            wx_q        <= '0;
            wy_q        <= '0;
            wren_q      <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            sealed_q    <= sealed_d;
            addr_q      <= addr_d;
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            wren_q      <= wren_d;
            pend_rd_q   <= pend_rd_d;
            pend_err_q  <= pend_err_d;
            rsp_valid_q <= pend_rd_q;
            rsp_err_q   <= pend_err_q;
        end
    end

    // Sealing uses the pre-edge sealed_q, so a write in the seal cycle still lands.
    always_comb begin
        count_d    = count_q;
        sealed_d   = sealed_q;
        addr_d     = addr_q;
        wx_d       = wx_q;
        wy_d       = wy_q;
        wren_d     = 1'b0;
        pend_rd_d  = 1'b0;
        pend_err_d = 1'b0;
        if (bus.clear) begin
            count_d  = '0;
            sealed_d = 1'b0;
        end else begin
            if (gnt == GNT_WR) begin
                count_d = count_q + 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wx_d    = bus.wr_x;
                wy_d    = bus.wr_y;
                wren_d  = 1'b1;
            end else if (gnt == GNT_RD) begin
                addr_d     = bus.rd_addr;
                pend_rd_d  = 1'b1;
                pend_err_d = ({1'b0, bus.rd_addr} >= count_q);
            end
            if (bus.seal) begin
                sealed_d = 1'b1;
            end
        end
    end

    assign bus.wr_ready     = (gnt == GNT_WR);
    assign bus.rd_ready     = (gnt == GNT_RD);
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.sealed       = sealed_q;
    assign bus.xmem_address = addr_q;
    assign bus.ymem_address = addr_q;
    assign bus.xmem_data    = wx_q;
    assign bus.ymem_data    = wy_q;
    assign bus.xmem_wren    = wren_q;
    assign bus.ymem_wren    = wren_q;

    // RAM data is only passed through for a valid, in-range response.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_valid_q & rsp_err_q;
    assign bus.rsp_x     = (rsp_valid_q & ~rsp_err_q) ? bus.xmem_q : '0;
    assign bus.rsp_y     = (rsp_valid_q & ~rsp_err_q) ? bus.ymem_q : '0;

`ifdef COORD_ARB_PERF_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] stall_q, stall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            conflict_q <= conflict_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        stall_d    = stall_q;
        if (bus.clear) begin
            conflict_d = '0;
            stall_d    = '0;
        end else begin
            if (wr_elig && rd_elig && (conflict_q != 16'hFFFF)) begin
                conflict_d = conflict_q + 16'd1;
            end
            if (bus.wr_valid && !bus.wr_ready && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    assign bus.conflict_cnt = conflict_q;
    assign bus.wr_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_coord_mem_arbiter.sv
// Self-checking bench for coord_mem_arbiter: directed vector table, corner sequences
// and random traffic against a table-level reference model (COORD_ARB_PERF_EN aware).
module tb_coord_mem_arbiter;
    import coord_mem_pkg::*;

    localparam int AW    = COORD_ADDR_W;
    localparam int DW    = COORD_DATA_W;
    localparam int DEPTH = COORD_DEPTH;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coord_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    coord_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural single-port RAMs: registered address, one cycle read latency.
    logic [DW-1:0] xram [DEPTH];
    logic [DW-1:0] yram [DEPTH];

    always @(posedge clk) begin
        if (bus.xmem_wren) xram[bus.xmem_address] <= bus.xmem_data;
        if (bus.ymem_wren) yram[bus.ymem_address] <= bus.ymem_data;
        bus.xmem_q <= xram[bus.xmem_address];
        bus.ymem_q <= yram[bus.ymem_address];
    end

    // Reference model: table contents, fill level, seal flag and last conflict winner.
    typedef struct {
        int            due;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        bit            err;
    } rsp_t;

    coord_t refMem [DEPTH];
    int     refCount   = 0;
    bit     refSealed  = 1'b0;
    bit     refLastRd  = 1'b1;
    rsp_t   rspQ [$];
`ifdef COORD_ARB_PERF_EN
    int     refConf    = 0;
    int     refStall   = 0;
`endif

    int errors = 0;
    int checks = 0;
    bit gw, gr;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        rsp_t r;
        checkVal("count", 32'(bus.count), refCount);
        checkVal("full", 32'(bus.full), 32'(refCount == DEPTH));
        checkVal("sealed", 32'(bus.sealed), 32'(refSealed));
        if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
            r = rspQ.pop_front();
            checkVal("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkVal("rsp_x", 32'(bus.rsp_x), 32'(r.x));
            checkVal("rsp_y", 32'(bus.rsp_y), 32'(r.y));
            checkVal("rsp_err", 32'(bus.rsp_err), 32'(r.err));
        end else begin
            checkVal("rsp_idle", 32'(bus.rsp_valid), 32'd0);
        end
`ifdef COORD_ARB_PERF_EN
        checkVal("conflict_cnt", 32'(bus.conflict_cnt), refConf);
        checkVal("wr_stall_cnt", 32'(bus.wr_stall_cnt), refStall);
`endif
    endtask

    task automatic applyStimulus(input bit wv, input logic [DW-1:0] wx, input logic [DW-1:0] wy,
                                 input bit sl, input bit rv, input logic [AW-1:0] ra,
                                 input bit clr, output bit gotWr, output bit gotRd);
        bit   wrElig, rdElig, expWr, expRd, e;
        rsp_t r;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_x     = wx;
        bus.wr_y     = wy;
        bus.seal     = sl;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        bus.clear    = clr;
        #1;
        checkOutput();
        wrElig = wv && !refSealed && (refCount != DEPTH) && !clr;
        rdElig = rv && !clr;
        if (wrElig && rdElig) begin
            expWr     = refLastRd;
            expRd     = !refLastRd;
            refLastRd = expRd;
        end else begin
            expWr = wrElig;
            expRd = rdElig;
        end
        gotWr = bus.wr_ready;
        gotRd = bus.rd_ready;
        checkVal("wr_ready", 32'(gotWr), 32'(expWr));
        checkVal("rd_ready", 32'(gotRd), 32'(expRd));
`ifdef COORD_ARB_PERF_EN
        if (clr) begin
            refConf  = 0;
            refStall = 0;
        end else begin
            if (wrElig && rdElig && refConf < 65535) refConf++;
            if (wv && !expWr && refStall < 65535) refStall++;
        end
`endif
        if (expRd) begin
            e     = (int'(ra) >= refCount);
            r.due = cyc + 2;
            r.err = e;
            r.x   = e ? '0 : refMem[ra].x;
            r.y   = e ? '0 : refMem[ra].y;
            rspQ.push_back(r);
        end
        if (expWr) begin
            refMem[refCount] = '{x: wx, y: wy};
            refCount++;
        end
        if (clr) begin
            refCount  = 0;
            refSealed = 1'b0;
        end else if (sl) begin
            refSealed = 1'b1;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, gw, gr);
    endtask

    task automatic wrPair(input int x, input int y);
        applyStimulus(1'b1, DW'(x), DW'(y), 1'b0, 1'b0, '0, 1'b0, gw, gr);
    endtask

    task automatic rdIdx(input int a);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(a), 1'b0, gw, gr);
    endtask

    task automatic clearCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, gw, gr);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_x     = '0;
        bus.wr_y     = '0;
        bus.seal     = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.clear    = 1'b0;
        reset_n      = 1'b0;
        #1;
        checkVal("rst_count", 32'(bus.count), 32'd0);
        checkVal("rst_sealed", 32'(bus.sealed), 32'd0);
        checkVal("rst_full", 32'(bus.full), 32'd0);
        checkVal("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkVal("rst_rsp_x", 32'(bus.rsp_x), 32'd0);
        checkVal("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkVal("rst_wren", 32'({bus.xmem_wren, bus.ymem_wren}), 32'd0);
        checkVal("rst_addr", 32'({bus.xmem_address, bus.ymem_address}), 32'd0);
`ifdef COORD_ARB_PERF_EN
        checkVal("rst_perf", 32'({bus.conflict_cnt, bus.wr_stall_cnt}), 32'd0);
        refConf  = 0;
        refStall = 0;
`endif
        refCount  = 0;
        refSealed = 1'b0;
        refLastRd = 1'b1;
        rspQ.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit            wv;
        logic [DW-1:0] wx, wy;
        bit            rv;
        logic [AW-1:0] ra;
        bit            eWr, eRd;
        int            eCnt;
        bit            eRsp;
        logic [DW-1:0] eX, eY;
        bit            eErr;
    } vec_t;

    function automatic vec_t mk(bit wv, int wx, int wy, bit rv, int ra, bit eWr, bit eRd,
                                int eCnt, bit eRsp, int eX, int eY, bit eErr);
        vec_t v;
        v.wv = wv;   v.wx = wx[DW-1:0]; v.wy = wy[DW-1:0];
        v.rv = rv;   v.ra = ra[AW-1:0];
        v.eWr = eWr; v.eRd = eRd; v.eCnt = eCnt;
        v.eRsp = eRsp; v.eX = eX[DW-1:0]; v.eY = eY[DW-1:0]; v.eErr = eErr;
        return v;
    endfunction

    vec_t vecs [14];
    bit   rWv, rSl, rRv, rClr;

    initial begin
        vecs[0]  = mk(1, 1, 2,   0, 0,  1, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 3, 4,   0, 0,  1, 0, 1,  0, 0, 0, 0);
        vecs[2]  = mk(1, 5, 6,   0, 0,  1, 0, 2,  0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0,   1, 1,  0, 1, 3,  0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0,   1, 5,  0, 1, 3,  0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0,   0, 0,  0, 0, 3,  1, 3, 4, 0);
        vecs[6]  = mk(1, 9, 10,  1, 0,  1, 0, 3,  1, 0, 0, 1);
        vecs[7]  = mk(1, 11, 12, 1, 0,  0, 1, 4,  0, 0, 0, 0);
        vecs[8]  = mk(1, 11, 12, 1, 3,  1, 0, 4,  0, 0, 0, 0);
        vecs[9]  = mk(1, 13, 14, 1, 3,  0, 1, 5,  1, 1, 2, 0);
        vecs[10] = mk(1, 13, 14, 0, 0,  1, 0, 5,  0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0,   1, 5,  0, 1, 6,  1, 9, 10, 0);
        vecs[12] = mk(0, 0, 0,   0, 0,  0, 0, 6,  0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0,   0, 0,  0, 0, 6,  1, 13, 14, 0);

        doReset();

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].wv, vecs[i].wx, vecs[i].wy, 1'b0,
                          vecs[i].rv, vecs[i].ra, 1'b0, gw, gr);
            checkVal($sformatf("vec%0d_wr_ready", i), 32'(gw), 32'(vecs[i].eWr));
            checkVal($sformatf("vec%0d_rd_ready", i), 32'(gr), 32'(vecs[i].eRd));
            checkVal($sformatf("vec%0d_count", i), 32'(bus.count), vecs[i].eCnt);
            checkVal($sformatf("vec%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].eRsp));
            if (vecs[i].eRsp) begin
                checkVal($sformatf("vec%0d_rsp_xy", i), 32'({bus.rsp_x, bus.rsp_y}),
                         32'({vecs[i].eX, vecs[i].eY}));
                checkVal($sformatf("vec%0d_rsp_err", i), 32'(bus.rsp_err), 32'(vecs[i].eErr));
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("ram_x%0d", i), 32'(xram[i]), 2 * i + 1);
            checkVal($sformatf("ram_y%0d", i), 32'(yram[i]), 2 * i + 2);
        end
`ifdef COORD_ARB_PERF_EN
        checkVal("conflict_after_table", 32'(bus.conflict_cnt), 32'd4);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            rWv  = ($urandom_range(0, 1) == 1);
            rRv  = ($urandom_range(0, 1) == 1);
            rSl  = ($urandom_range(0, 39) == 0);
            rClr = ($urandom_range(0, 29) == 0);
            applyStimulus(rWv, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), rSl,
                          rRv, AW'($urandom_range(0, 15)), rClr, gw, gr);
        end

        $display("[TB] fill to capacity");
        clearCycle();
        for (int i = 0; i < DEPTH; i++) wrPair(i, 255 - i);
        idle();
        checkVal("fill_count", 32'(bus.count), 32'd256);
        checkVal("fill_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wrPair(8'hAA, 8'h55);
            checkVal("fill_overflow_ready", 32'(gw), 32'd0);
        end
        checkVal("fill_count_hold", 32'(bus.count), 32'd256);
        rdIdx(255);
        idle();
        idle();
        checkVal("fill_rd255", 32'({bus.rsp_valid, bus.rsp_x, bus.rsp_y}), 32'({1'b1, 8'd255, 8'd0}));

        $display("[TB] seal with simultaneous write");
        clearCycle();
        wrPair(20, 21);
        applyStimulus(1'b1, 8'd7, 8'd8, 1'b1, 1'b0, '0, 1'b0, gw, gr);
        checkVal("seal_write_ready", 32'(gw), 32'd1);
        idle();
        checkVal("seal_sealed", 32'(bus.sealed), 32'd1);
        checkVal("seal_count", 32'(bus.count), 32'd2);
        wrPair(1, 1);
        checkVal("seal_blocked", 32'(gw), 32'd0);
        rdIdx(1);
        idle();
        idle();
        checkVal("seal_rd_xy", 32'({bus.rsp_x, bus.rsp_y}), 32'({8'd7, 8'd8}));

        $display("[TB] reset with read in flight");
        rdIdx(0);
        doReset();
        idle();
        idle();
        idle();

        $display("[TB] clear after sealing");
        wrPair(2, 3);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, gw, gr);
        wrPair(4, 5);
        checkVal("sealed_reject", 32'(gw), 32'd0);
        clearCycle();
        wrPair(33, 44);
        checkVal("clear_write_ready", 32'(gw), 32'd1);
        idle();
        checkVal("clear_count", 32'(bus.count), 32'd1);
        checkVal("clear_sealed", 32'(bus.sealed), 32'd0);
        rdIdx(0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
